// File: rtl/dual_issue_scoreboard.sv
// dual_issue_scoreboard: per-register latency scoreboard and even/odd dual-issue arbiter; HAZ_FWD_EN makes sources readable at the forward point instead of RF writeback
module dual_issue_scoreboard #(
  parameter int NUM_REGS = 128,
  parameter int ADDR_W = 7,
  parameter int LAT_W = 4,
  parameter int WB_EXTRA = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              i1_valid,
  input  logic              i1_pipe,
  input  logic [ADDR_W-1:0] i1_ra,
  input  logic [ADDR_W-1:0] i1_rb,
  input  logic [ADDR_W-1:0] i1_rc,
  input  logic [2:0]        i1_src_en,
  input  logic [ADDR_W-1:0] i1_rt,
  input  logic              i1_wr_en,
  input  logic [LAT_W-1:0]  i1_lat,
  input  logic              i2_valid,
  input  logic              i2_pipe,
  input  logic [ADDR_W-1:0] i2_ra,
  input  logic [ADDR_W-1:0] i2_rb,
  input  logic [ADDR_W-1:0] i2_rc,
  input  logic [2:0]        i2_src_en,
  input  logic [ADDR_W-1:0] i2_rt,
  input  logic              i2_wr_en,
  input  logic [LAT_W-1:0]  i2_lat,
  output logic              issue1,
  output logic              issue2,
  output logic              stall,
  output logic [ADDR_W:0]   busy_cnt
);
  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [LAT_W-1:0] nxt [NUM_REGS];
  logic [LAT_W-1:0] lf1, lf2, l1, l2, d;
  logic [ADDR_W:0] nxt_busy;
  logic rdy1, rdy2, raw, waw, ld1, ld2;
  assign lf1 = (i1_lat == '0) ? LAT_W'(1) : i1_lat;
  assign lf2 = (i2_lat == '0) ? LAT_W'(1) : i2_lat;
`ifdef HAZ_FWD_EN
  assign l1 = lf1;
  assign l2 = lf2;
`else
  logic [LAT_W:0] s1, s2;
  assign s1 = {1'b0, lf1} + (LAT_W+1)'(WB_EXTRA);
  assign s2 = {1'b0, lf2} + (LAT_W+1)'(WB_EXTRA);
  assign l1 = s1[LAT_W] ? '1 : s1[LAT_W-1:0];
  assign l2 = s2[LAT_W] ? '1 : s2[LAT_W-1:0];
`endif
  always_comb begin
    rdy1 = (!i1_src_en[2] || cnt[i1_ra] == '0) && (!i1_src_en[1] || cnt[i1_rb] == '0) && (!i1_src_en[0] || cnt[i1_rc] == '0);
    rdy2 = (!i2_src_en[2] || cnt[i2_ra] == '0) && (!i2_src_en[1] || cnt[i2_rb] == '0) && (!i2_src_en[0] || cnt[i2_rc] == '0);
    raw = i1_wr_en && ((i2_src_en[2] && i2_ra == i1_rt) || (i2_src_en[1] && i2_rb == i1_rt) || (i2_src_en[0] && i2_rc == i1_rt));
    waw = i1_wr_en && i2_wr_en && i2_rt == i1_rt;
  end
  assign issue1 = !reset && !flush && i1_valid && rdy1;
  assign issue2 = issue1 && i2_valid && rdy2 && (i1_pipe != i2_pipe) && !raw && !waw;
  assign stall = !reset && !flush && ((i1_valid && !issue1) || (i2_valid && !issue2));
  always_comb begin
    nxt_busy = '0;
    d = '0;
    ld1 = 1'b0;
    ld2 = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      d = cnt[r] - LAT_W'(cnt[r] != '0);
      ld1 = issue1 && i1_wr_en && i1_rt == ADDR_W'(r);
      ld2 = issue2 && i2_wr_en && i2_rt == ADDR_W'(r);
      nxt[r] = ld1 ? ((d > l1) ? d : l1) : ld2 ? ((d > l2) ? d : l2) : d;
      nxt_busy = nxt_busy + (ADDR_W+1)'(nxt[r] != '0);
    end
  end
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) cnt[r] <= reset ? '0 : nxt[r];
    busy_cnt <= reset ? '0 : nxt_busy;
  end
endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// tb_dual_issue_scoreboard: table-driven and sequence checks of the dual-issue scoreboard
module tb_dual_issue_scoreboard;
`ifdef HAZ_FWD_EN
  localparam int WB = 0;
`else
  localparam int WB = 2;
`endif
  typedef struct packed {
    logic v;
    logic p;
    logic [6:0] ra;
    logic [6:0] rb;
    logic [6:0] rc;
    logic [2:0] en;
    logic [6:0] rt;
    logic wr;
    logic [3:0] lat;
  } slot_t;
  typedef struct {
    slot_t s1;
    slot_t s2;
    logic fl;
    logic e1;
    logic e2;
    logic es;
    int eb;
  } vec_t;
  logic clk = 0, reset = 1, flush = 0;
  slot_t d1 = '0, d2 = '0;
  logic issue1, issue2, stall;
  logic [7:0] busy_cnt;
  int nvec = 0, nfail = 0;
  vec_t tbl [14];
  always #5 clk = ~clk;
  dual_issue_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush),
    .i1_valid(d1.v), .i1_pipe(d1.p), .i1_ra(d1.ra), .i1_rb(d1.rb), .i1_rc(d1.rc),
    .i1_src_en(d1.en), .i1_rt(d1.rt), .i1_wr_en(d1.wr), .i1_lat(d1.lat),
    .i2_valid(d2.v), .i2_pipe(d2.p), .i2_ra(d2.ra), .i2_rb(d2.rb), .i2_rc(d2.rc),
    .i2_src_en(d2.en), .i2_rt(d2.rt), .i2_wr_en(d2.wr), .i2_lat(d2.lat),
    .issue1(issue1), .issue2(issue2), .stall(stall), .busy_cnt(busy_cnt)
  );
  function automatic slot_t mk(input logic v, input logic p, input logic [6:0] ra, input logic [6:0] rb,
                               input logic [6:0] rc, input logic [2:0] en, input logic [6:0] rt,
                               input logic wr, input logic [3:0] lat);
    return '{v: v, p: p, ra: ra, rb: rb, rc: rc, en: en, rt: rt, wr: wr, lat: lat};
  endfunction
  function automatic int leff(input int lat);
    int l = (lat == 0 ? 1 : lat) + WB;
    return l > 15 ? 15 : l;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic dep(input logic [6:0] r, input int stalls, input string nm);
    for (int k = 0; k <= stalls; k++) begin
      d1 = mk(1, 0, r, 0, 0, 3'b100, 0, 0, 1);
      d2 = '0;
      @(negedge clk);
      chk({nm, " issue1"}, issue1, k == stalls);
      chk({nm, " stall"}, stall, k < stalls);
      next_cyc();
    end
    d1 = '0;
  endtask
  task automatic do_reset;
    reset = 1;
    d1 = '0;
    d2 = '0;
    flush = 0;
    next_cyc();
    reset = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{mk(1,0,0,0,0,0,5,1,2),  mk(1,1,9,0,0,3'b100,0,0,1), 0, 1, 1, 0, 1};
    tbl[1]  = '{mk(1,0,0,0,0,0,1,1,1),  mk(1,0,0,0,0,0,2,1,1),      0, 1, 0, 1, 1};
    tbl[2]  = '{mk(1,0,0,0,0,0,3,1,3),  mk(1,1,0,3,0,3'b010,0,0,1), 0, 1, 0, 1, 1};
    tbl[3]  = '{mk(1,0,0,0,0,0,4,1,7),  mk(1,1,0,0,0,0,4,1,2),      0, 1, 0, 1, 1};
    tbl[4]  = '{mk(1,0,0,0,0,0,4,0,7),  mk(1,1,0,0,0,0,4,1,2),      0, 1, 1, 0, 1};
    tbl[5]  = '{mk(1,0,0,0,0,0,3,1,3),  mk(1,1,3,3,3,3'b000,7,1,1), 0, 1, 1, 0, 2};
    tbl[6]  = '{mk(1,0,0,0,0,0,5,1,2),  mk(1,1,0,0,0,0,6,1,2),      1, 0, 0, 0, 0};
    tbl[7]  = '{mk(1,0,0,0,0,0,20,1,3), '0,                         0, 1, 0, 0, 1};
    tbl[8]  = '{'0,                     mk(1,1,0,0,0,0,21,1,3),     0, 0, 0, 1, 0};
    tbl[9]  = '{'0,                     '0,                         0, 0, 0, 0, 0};
    tbl[10] = '{mk(1,1,0,0,0,0,22,1,3), mk(1,0,0,0,0,0,23,1,3),     0, 1, 1, 0, 2};
    tbl[11] = '{mk(1,0,0,0,0,0,8,1,3),  mk(1,1,0,0,8,3'b001,0,0,1), 0, 1, 0, 1, 1};
    tbl[12] = '{mk(1,0,0,0,0,0,8,0,3),  mk(1,1,0,0,8,3'b001,0,0,1), 0, 1, 1, 0, 0};
    tbl[13] = '{mk(1,0,0,0,0,0,9,1,0),  '0,                         0, 1, 0, 0, 1};
    next_cyc();
    for (int i = 0; i < 14; i++) begin
      reset = 1;
      d1 = tbl[i].s1;
      d2 = tbl[i].s2;
      flush = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("vec%0d reset issue1", i), issue1, 0);
      chk($sformatf("vec%0d reset issue2", i), issue2, 0);
      chk($sformatf("vec%0d reset stall", i), stall, 0);
      next_cyc();
      reset = 0;
      @(negedge clk);
      chk($sformatf("vec%0d busy0", i), busy_cnt, 0);
      chk($sformatf("vec%0d issue1", i), issue1, tbl[i].e1);
      chk($sformatf("vec%0d issue2", i), issue2, tbl[i].e2);
      chk($sformatf("vec%0d stall", i), stall, tbl[i].es);
      next_cyc();
      d1 = '0;
      d2 = '0;
      flush = 0;
      @(negedge clk);
      chk($sformatf("vec%0d busy", i), busy_cnt, tbl[i].eb);
      next_cyc();
    end
    do_reset();
    d1 = mk(1,0,0,0,0,0,5,1,2);
    d2 = mk(1,1,9,0,0,3'b100,0,0,1);
    @(negedge clk);
    chk("seqA pair issue2", issue2, 1);
    next_cyc();
    dep(5, leff(2), "seqA dep r5");
    @(negedge clk);
    chk("seqA busy drained", busy_cnt, 0);
    next_cyc();
    d1 = mk(1,0,0,0,0,0,10,1,6);
    @(negedge clk);
    chk("seqB issue", issue1, 1);
    next_cyc();
    dep(10, leff(6), "seqB dep r10");
    d1 = mk(1,0,0,0,0,0,1,1,1);
    d2 = mk(1,0,0,0,0,0,2,1,1);
    @(negedge clk);
    chk("seqC issue1", issue1, 1);
    chk("seqC issue2", issue2, 0);
    chk("seqC stall", stall, 1);
    next_cyc();
    d1 = mk(1,0,0,0,0,0,2,1,1);
    d2 = '0;
    @(negedge clk);
    chk("seqC replay issue1", issue1, 1);
    chk("seqC replay stall", stall, 0);
    next_cyc();
    d1 = mk(1,0,0,0,0,0,3,1,3);
    d2 = mk(1,1,0,3,0,3'b010,0,0,1);
    @(negedge clk);
    chk("seqD issue2", issue2, 0);
    chk("seqD stall", stall, 1);
    next_cyc();
    dep(3, leff(3), "seqD dep r3");
    do_reset();
    d1 = mk(1,0,0,0,0,0,4,1,7);
    @(negedge clk);
    chk("seqE older issue", issue1, 1);
    next_cyc();
    d1 = mk(1,0,0,0,0,0,4,1,2);
    @(negedge clk);
    chk("seqE newer issue", issue1, 1);
    chk("seqE newer stall", stall, 0);
    next_cyc();
    dep(4, leff(7) - 1, "seqE dep r4");
    d1 = mk(1,0,0,0,0,0,12,1,5);
    @(negedge clk);
    chk("seqF issue", issue1, 1);
    next_cyc();
    flush = 1;
    d1 = mk(1,0,0,0,0,0,30,1,3);
    d2 = mk(1,1,0,0,0,0,31,1,3);
    @(negedge clk);
    chk("seqF flush issue1", issue1, 0);
    chk("seqF flush issue2", issue2, 0);
    chk("seqF flush stall", stall, 0);
    chk("seqF flush busy", busy_cnt, 1);
    next_cyc();
    flush = 0;
    dep(12, leff(5) - 1, "seqF dep r12");
    @(negedge clk);
    chk("seqF busy drained", busy_cnt, 0);
    next_cyc();
    d1 = mk(1,0,0,0,0,0,13,1,7);
    next_cyc();
    reset = 1;
    d1 = mk(1,0,13,0,0,3'b100,0,0,1);
    @(negedge clk);
    chk("seqF reset issue1", issue1, 0);
    chk("seqF reset stall", stall, 0);
    next_cyc();
    reset = 0;
    d1 = '0;
    @(negedge clk);
    chk("seqF busy after reset", busy_cnt, 0);
    next_cyc();
    dep(13, 0, "seqF dep r13");
    d1 = mk(1,0,0,0,0,0,14,1,15);
    next_cyc();
    dep(14, leff(15), "lat15 dep r14");
    d1 = mk(1,0,0,0,0,0,15,1,0);
    next_cyc();
    dep(15, leff(0), "lat0 dep r15");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
